// File: rtl/oled_init_sequencer.sv
// Power-up and command sequencer for the SSD1331 (PmodOLEDrgb) behind a byte-wide SPI engine.
// Optional: define OLED_CLEAR_ON_INIT_EN to append a clear-window command after display-on.
module oled_init_sequencer #(
  parameter int unsigned T_PWR_CYC = 2_000_000,
  parameter int unsigned T_RES_CYC = 300,
  parameter int unsigned T_VCC_CYC = 2_500_000,
  parameter int unsigned T_ON_CYC  = 10_000_000
) (
  input  logic       i_clk,
  input  logic       i_n_reset,
  input  logic       i_init_start,
  output logic       o_spi_start,
  output logic [7:0] o_spi_byte,
  input  logic       i_spi_done,
  output logic       o_dc,
  output logic       o_res_n,
  output logic       o_vccen,
  output logic       o_pmoden,
  input  logic       i_usr_req,
  input  logic       i_usr_dc,
  input  logic [7:0] i_usr_byte,
  output logic       o_usr_ack,
  output logic       o_ready,
  output logic       o_busy
);

  typedef enum logic [3:0] {
    IDLE, PWR_ON, RES_LOW, RES_REC, CMD_LOAD, CMD_WAIT, VCC_ON, DON_LOAD,
    DON_WAIT, CLR_LOAD, CLR_WAIT, CLR_DLY, ON_DLY, READY, USR_WAIT
  } state_t;

  localparam logic [31:0] PWR_LD   = 32'(T_PWR_CYC - 1);
  localparam logic [31:0] RES_LD   = 32'(T_RES_CYC - 1);
  localparam logic [31:0] VCC_LD   = 32'(T_VCC_CYC - 1);
  localparam logic [31:0] ON_LD    = 32'(T_ON_CYC - 1);
  localparam logic [5:0]  LAST_IDX = 6'd38;
  localparam logic [7:0]  DISP_ON  = 8'hAF;

  state_t      state;
  logic [31:0] dly_cnt;
  logic [5:0]  idx;
`ifdef OLED_CLEAR_ON_INIT_EN
  logic [2:0]  clr_idx;
`endif

  function automatic logic [7:0] rom_byte(input logic [5:0] i);
    case (i)
      6'd0:  rom_byte = 8'hFD;  6'd1:  rom_byte = 8'h12;  6'd2:  rom_byte = 8'hAE;
      6'd3:  rom_byte = 8'hA0;  6'd4:  rom_byte = 8'h72;  6'd5:  rom_byte = 8'hA1;
      6'd6:  rom_byte = 8'h00;  6'd7:  rom_byte = 8'hA2;  6'd8:  rom_byte = 8'h00;
      6'd9:  rom_byte = 8'hA4;  6'd10: rom_byte = 8'hA8;  6'd11: rom_byte = 8'h3F;
      6'd12: rom_byte = 8'hAD;  6'd13: rom_byte = 8'h8E;  6'd14: rom_byte = 8'hB0;
      6'd15: rom_byte = 8'h0B;  6'd16: rom_byte = 8'hB1;  6'd17: rom_byte = 8'h31;
      6'd18: rom_byte = 8'hB3;  6'd19: rom_byte = 8'hF0;  6'd20: rom_byte = 8'h8A;
      6'd21: rom_byte = 8'h64;  6'd22: rom_byte = 8'h8B;  6'd23: rom_byte = 8'h78;
      6'd24: rom_byte = 8'h8C;  6'd25: rom_byte = 8'h64;  6'd26: rom_byte = 8'hBB;
      6'd27: rom_byte = 8'h3A;  6'd28: rom_byte = 8'hBE;  6'd29: rom_byte = 8'h3E;
      6'd30: rom_byte = 8'h87;  6'd31: rom_byte = 8'h06;  6'd32: rom_byte = 8'h81;
      6'd33: rom_byte = 8'h91;  6'd34: rom_byte = 8'h82;  6'd35: rom_byte = 8'h50;
      6'd36: rom_byte = 8'h83;  6'd37: rom_byte = 8'h7D;  6'd38: rom_byte = 8'h2E;
      default: rom_byte = 8'h00;
    endcase
  endfunction

`ifdef OLED_CLEAR_ON_INIT_EN
  // Clear-window over the full 96x64 panel: opcode, col0, row0, col1, row1.
  function automatic logic [7:0] clr_byte(input logic [2:0] i);
    case (i)
      3'd0:    clr_byte = 8'h25;
      3'd3:    clr_byte = 8'h5F;
      3'd4:    clr_byte = 8'h3F;
      default: clr_byte = 8'h00;
    endcase
  endfunction
`endif

  // Every output is a register written on the transition into the state that owns it,
  // so the pins change exactly on state entry with no combinational glitches.
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      state       <= IDLE;
      dly_cnt     <= '0;
      idx         <= '0;
`ifdef OLED_CLEAR_ON_INIT_EN
      clr_idx     <= '0;
`endif
      o_spi_start <= 1'b0;
      o_spi_byte  <= '0;
      o_dc        <= 1'b0;
      o_res_n     <= 1'b1;
      o_vccen     <= 1'b0;
      o_pmoden    <= 1'b0;
      o_usr_ack   <= 1'b0;
      o_ready     <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      // NOTE: nonblocking defaults first; any branch below that re-assigns wins,
      // which turns o_spi_start and o_usr_ack into single-cycle pulses.
      o_spi_start <= 1'b0;
      o_usr_ack   <= 1'b0;

      case (state)
        IDLE: begin
          if (i_init_start) begin
            state    <= PWR_ON;
            o_pmoden <= 1'b1;
            o_busy   <= 1'b1;
            dly_cnt  <= PWR_LD;
          end
        end

        PWR_ON: begin
          if (dly_cnt == '0) begin
            state   <= RES_LOW;
            o_res_n <= 1'b0;
            dly_cnt <= RES_LD;
          end else begin
            dly_cnt <= dly_cnt - 32'd1;
          end
        end

        RES_LOW: begin
          if (dly_cnt == '0) begin
            state   <= RES_REC;
            o_res_n <= 1'b1;
            dly_cnt <= RES_LD;
          end else begin
            dly_cnt <= dly_cnt - 32'd1;
          end
        end

        RES_REC: begin
          if (dly_cnt == '0) begin
            state       <= CMD_LOAD;
            idx         <= '0;
            o_spi_start <= 1'b1;
            o_spi_byte  <= rom_byte(6'd0);
            o_dc        <= 1'b0;
          end else begin
            dly_cnt <= dly_cnt - 32'd1;
          end
        end

        CMD_LOAD: state <= CMD_WAIT;

        CMD_WAIT: begin
          if (i_spi_done) begin
            if (idx == LAST_IDX) begin
              state   <= VCC_ON;
              o_vccen <= 1'b1;
              dly_cnt <= VCC_LD;
            end else begin
              state       <= CMD_LOAD;
              idx         <= idx + 6'd1;
              o_spi_start <= 1'b1;
              o_spi_byte  <= rom_byte(idx + 6'd1);
            end
          end
        end

        VCC_ON: begin
          if (dly_cnt == '0) begin
            state       <= DON_LOAD;
            o_spi_start <= 1'b1;
            o_spi_byte  <= DISP_ON;
            o_dc        <= 1'b0;
          end else begin
            dly_cnt <= dly_cnt - 32'd1;
          end
        end

        DON_LOAD: state <= DON_WAIT;

        DON_WAIT: begin
          if (i_spi_done) begin
`ifdef OLED_CLEAR_ON_INIT_EN
            state       <= CLR_LOAD;
            clr_idx     <= '0;
            o_spi_start <= 1'b1;
            o_spi_byte  <= clr_byte(3'd0);
            o_dc        <= 1'b0;
`else
            state   <= ON_DLY;
            dly_cnt <= ON_LD;
`endif
          end
        end

`ifdef OLED_CLEAR_ON_INIT_EN
        CLR_LOAD: state <= CLR_WAIT;

        CLR_WAIT: begin
          if (i_spi_done) begin
            if (clr_idx == 3'd4) begin
              state   <= CLR_DLY;
              dly_cnt <= RES_LD;
            end else begin
              state       <= CLR_LOAD;
              clr_idx     <= clr_idx + 3'd1;
              o_spi_start <= 1'b1;
              o_spi_byte  <= clr_byte(clr_idx + 3'd1);
            end
          end
        end

        CLR_DLY: begin
          if (dly_cnt == '0) begin
            state   <= ON_DLY;
            dly_cnt <= ON_LD;
          end else begin
            dly_cnt <= dly_cnt - 32'd1;
          end
        end
`endif

        ON_DLY: begin
          if (dly_cnt == '0) begin
            state   <= READY;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
          end else begin
            dly_cnt <= dly_cnt - 32'd1;
          end
        end

        // A held request is re-accepted only once the ack pulse has gone low.
        READY: begin
          if (i_usr_req && !o_usr_ack) begin
            state       <= USR_WAIT;
            o_spi_start <= 1'b1;
            o_spi_byte  <= i_usr_byte;
            o_dc        <= i_usr_dc;
            o_busy      <= 1'b1;
          end
        end

        USR_WAIT: begin
          if (i_spi_done) begin
            state     <= READY;
            o_usr_ack <= 1'b1;
            o_busy    <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/oled_init_sequencer.md
Name: oled_init_sequencer

Overview:
- Power-up and command sequencer for the PmodOLEDrgb (SSD1331) SPI byte transmitter.
- Drives the panel power and reset pins (PMODEN, VCCEN, RES, D/C) with the datasheet timing.
- Streams a fixed init-command ROM through the SPI engine using a one-byte start/done handshake.
- After init it hands the SPI engine to a single user requester (pixel/command writer) as a byte pass-through.

Parameters:
- T_PWR_CYC, 2_000_000, cycles after PMODEN=1 before reset (20 ms @100 MHz)
- T_RES_CYC, 300, cycles RES held low, and also the recovery time after release (3 us)
- T_VCC_CYC, 2_500_000, cycles after VCCEN=1 before display-on (25 ms)
- T_ON_CYC, 10_000_000, cycles after display-on before ready (100 ms)

Ports:
- i_clk  in  1  system clock
- i_n_reset  in  1  asynchronous active-low reset
- i_init_start  in  1  pulse; starts the power-up sequence from IDLE
- o_spi_start  out  1  one-cycle pulse; SPI engine sends o_spi_byte
- o_spi_byte  out  8  byte to transmit; stable from start until done
- i_spi_done  in  1  one-cycle pulse; SPI byte finished
- o_dc  out  1  panel D/C (0 = command, 1 = data); stable during the byte
- o_res_n  out  1  panel RES, active low
- o_vccen  out  1  panel VCC enable
- o_pmoden  out  1  Pmod logic power enable
- i_usr_req  in  1  user byte request (level)
- i_usr_dc  in  1  user D/C, captured at accept
- i_usr_byte  in  8  user byte, captured at accept
- o_usr_ack  out  1  one-cycle pulse; user byte sent
- o_ready  out  1  init complete; user path open
- o_busy  out  1  a sequence or transfer is in progress

Behaviour:
- Reset values (asynchronous, taking effect at any point, including mid-sequence): state IDLE; o_spi_start=0, o_spi_byte=0, o_dc=0, o_res_n=1, o_vccen=0, o_pmoden=0, o_usr_ack=0, o_ready=0, o_busy=0; all counters 0.
- Delay counter: 32-bit down-counter loaded with T-1 on state entry. A delay state lasts exactly T cycles.
- Byte index: 6-bit counter; runs 0..38 and does not wrap.
- Command ROM, 39 bytes, index 0..38: FD 12 AE A0 72 A1 00 A2 00 A4 A8 3F AD 8E B0 0B B1 31 B3 F0 8A 64 8B 78 8C 64 BB 3A BE 3E 87 06 81 91 82 50 83 7D 2E.
- States and transitions:
  - IDLE: on i_init_start go to PWR_ON.
  - PWR_ON: o_pmoden=1; wait T_PWR_CYC.
  - RES_LOW: o_res_n=0; wait T_RES_CYC.
  - RES_REC: o_res_n=1; wait T_RES_CYC.
  - CMD_LOAD: 1 cycle; o_spi_start=1, o_spi_byte=ROM[idx], o_dc=0.
  - CMD_WAIT: hold byte and D/C. On i_spi_done: if idx==38 go to VCC_ON, else idx+1 and go to CMD_LOAD.
  - VCC_ON: o_vccen=1; wait T_VCC_CYC.
  - DON_LOAD: 1 cycle; start byte AF, dc=0.
  - DON_WAIT: on i_spi_done go to ON_DLY.
  - ON_DLY: wait T_ON_CYC.
  - READY: o_ready=1.
  - USR_WAIT: on i_spi_done go to READY, with o_usr_ack=1 in the first READY cycle.
- Output persistence: o_pmoden, o_vccen and o_ready stay high once set, until reset.
- User path: in READY, a request is accepted when i_usr_req=1 and o_usr_ack=0. On accept, capture byte and dc, pulse o_spi_start for 1 cycle, then go to USR_WAIT. The requester drops or updates i_usr_req on the ack cycle.
- Ignored inputs:
  - i_init_start outside IDLE.
  - i_usr_req outside READY (no ack is produced).
  - i_spi_done outside the *_WAIT states.
- o_busy: 1 in every state except IDLE and READY.
- Start latency: first o_pmoden=1 one cycle after i_init_start is sampled. A new o_spi_start comes 1 cycle after the i_spi_done edge for consecutive ROM bytes.

Optional Feature:
- OLED_CLEAR_ON_INIT_EN defined: after DON_WAIT, send a clear-window command, bytes 25 00 00 5F 3F with dc=0, via a CLR_LOAD/CLR_WAIT loop. Then wait T_RES_CYC before entering ON_DLY.
- Undefined: DON_WAIT goes directly to ON_DLY, and the total is 40 command bytes.

Test Plan:
- T_PWR=10, T_RES=3, T_VCC=12, T_ON=20; pulse i_init_start; SPI model returns done 8 cycles after start -> o_pmoden rises at cycle 1; o_res_n low for exactly 3 cycles starting at cycle 11; 39 bytes equal to the ROM with dc=0; o_vccen rises after byte 38 done; AF sent 12 cycles later; o_ready rises 20 cycles after AF done.
- In READY, i_usr_req=1, i_usr_dc=1, i_usr_byte=C3 -> one o_spi_start with byte C3 and dc=1; o_usr_ack single pulse one cycle after done; held req issues the next transfer the following cycle.
- i_usr_req=1 during init, plus spurious i_spi_done in PWR_ON -> no ack, no extra start; ROM order unaffected.
- Assert i_n_reset=0 while in CMD_WAIT at idx 17 -> all outputs return to reset values immediately; after release, i_init_start restarts from ROM[0]=FD.
- Second i_init_start at cycle 5 of PWR_ON -> ignored; timing identical to the first test.
- With OLED_CLEAR_ON_INIT_EN: bytes after AF are 25 00 00 5F 3F, then ready after T_RES + T_ON.
